gcd_rr_scheduler: RTL and testbench
===================================

Name: gcd_rr_scheduler

Overview:
- Shares one iterative subtractive-Euclid GCD engine among N_REQ requesters.
- Round-robin arbitration.
- Valid/ready handshake on each request port and on the single response port.
- Sits between the requester clients and the shared GCD resource; tags each result with the requester id.

Parameters:
- N_REQ, 4, number of requester ports (>=2).
- WIDTH, 8, operand and result width in bits.
- ID_W, $clog2(N_REQ), width of the requester id.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  per-requester operand-pair valid.
- req_ready  output  N_REQ  per-requester grant/accept, one-hot or zero.
- req_a  input  N_REQ*WIDTH  operand A; requester k occupies bits [k*WIDTH +: WIDTH].
- req_b  input  N_REQ*WIDTH  operand B; same packing as req_a.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  ID_W  index of the requester that owns the result.
- rsp_gcd  output  WIDTH  gcd(A,B).
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, x=y=0, rsp_valid=0, rsp_id=0, rsp_gcd=0, req_ready=0, busy=0. Reset mid-computation discards the job; no response is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE, grant selection:
  - Combinational grant g = first k with req_valid[k]=1, searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - req_ready[g]=1; all other req_ready bits are 0.
  - If no req_valid is high, req_ready=0 and the FSM stays in IDLE.
- IDLE, acceptance edge (a grant exists):
  - x<=A[g], y<=B[g], rsp_id<=g.
  - Transition to CALC.
- req_ready is 0 in CALC and DONE. Requesters hold valid and data stable until accepted; valid must not depend on ready.
- CALC, evaluated once per cycle in this priority order:
  - x==0: rsp_gcd<=y, go to DONE.
  - y==0: rsp_gcd<=x, go to DONE.
  - x==y: rsp_gcd<=x, go to DONE.
  - x>y: x<=x-y, stay in CALC.
  - otherwise: y<=y-x, stay in CALC.
  - gcd(0,0)=0.
- Latency: let S = number of subtraction steps. rsp_valid rises at acceptance edge + S + 1.
  - (12,8): S=2, latency 3.
  - (0,5): S=0, latency 1.
  - (255,1): S=254, latency 255.
- Arithmetic: all operations unsigned WIDTH bits. Subtraction never underflows because the larger value is always the minuend. No widening.
- DONE:
  - rsp_valid=1; rsp_gcd and rsp_id are held stable while rsp_ready=0 (unbounded backpressure).
  - Response handshake edge (rsp_valid && rsp_ready): rsp_valid<=0, rr_ptr<=(rsp_id+1) mod N_REQ, go to IDLE.
  - rsp_gcd and rsp_id retain their last values after the handshake.
- Throughput: minimum 3 cycles per job (accept, one CALC cycle, response). A new request is accepted no earlier than the cycle after the response handshake; no overlap.
- Fairness: a continuously requesting port waits at most N_REQ-1 jobs before it is granted.
- Simultaneous events: a request arriving during CALC/DONE waits with no loss. Deasserting req_valid before grant is a protocol violation and is not checked.

Test Plan:
- Reset then single request, port 0: A=12, B=8, rsp_ready=1 → rsp_valid high 3 cycles after accept, rsp_gcd=4, rsp_id=0, then returns to IDLE with rr_ptr=1.
- Zero and equal operands: (0,5) → 5 with latency 1; (7,0) → 7; (0,0) → 0; (9,9) → 9 with latency 1.
- All 4 ports valid continuously, port k offering (k+2, 2*(k+2)) → grant order 0,1,2,3,0; each rsp_gcd = k+2 tagged with the correct rsp_id; req_ready is never multi-hot.
- Backpressure: hold rsp_ready=0 for 20 cycles in DONE → rsp_valid, rsp_gcd and rsp_id stable; all req_ready=0 and busy=1 throughout; the result is delivered exactly once on release.
- Worst case and reset abort:
  - (255,1) → rsp_gcd=1 after exactly 255 cycles.
  - Repeat, but assert rst at cycle 100 → all outputs 0 immediately; no rsp_valid after rst falls.
  - The next request (48,18) → 6.
- Random regression: 2000 random WIDTH-bit pairs on random ports with random rsp_ready gaps → every rsp_gcd matches the reference gcd, and ids and per-port ordering are preserved.

Source files
------------

// File: rtl/gcd_rr_scheduler.sv
// rtl/gcd_rr_scheduler.sv - round-robin front end sharing one subtractive-Euclid GCD engine
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready  per-requester handshake; ready is one-hot or zero
//   req_a/req_b          packed operands, requester k at [k*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready  result handshake
//   rsp_id/rsp_gcd       owning requester and gcd(A,B)
//   busy                 engine occupied (CALC or DONE)
module gcd_rr_scheduler #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [WIDTH-1:0]       rsp_gcd,
   output logic                   busy
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [ID_W-1:0]  rr_ptr;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;

   logic             grant_found;
   logic [ID_W-1:0]  grant_id;
   logic [N_REQ-1:0] grant_vec;
   logic [WIDTH-1:0] grant_a;
   logic [WIDTH-1:0] grant_b;

   // Round-robin search split into two passes: ports at or above rr_ptr
   // first, then the wrapped-around ports below it.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      grant_vec   = '0;
      grant_a     = '0;
      grant_b     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!grant_found && req_valid[k] && (k >= int'(rr_ptr))) begin
            grant_found  = 1'b1;
            grant_id     = ID_W'(k);
            grant_vec[k] = 1'b1;
            grant_a      = req_a[k*WIDTH +: WIDTH];
            grant_b      = req_b[k*WIDTH +: WIDTH];
         end
      end
      for (int k = 0; k < N_REQ; k++) begin
         if (!grant_found && req_valid[k] && (k < int'(rr_ptr))) begin
            grant_found  = 1'b1;
            grant_id     = ID_W'(k);
            grant_vec[k] = 1'b1;
            grant_a      = req_a[k*WIDTH +: WIDTH];
            grant_b      = req_b[k*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Ready is masked during reset so no grant is advertised while the
   // engine is being cleared.
   always_comb begin
      state_next = state;
      req_ready  = '0;
      case (state)
         IDLE: begin
            if (grant_found && !rst) begin
               req_ready  = grant_vec;
               state_next = CALC;
            end
         end
         CALC: begin
            if ((x == '0) || (y == '0) || (x == y)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x       <= '0;
         y       <= '0;
         rr_ptr  <= '0;
         rsp_id  <= '0;
         rsp_gcd <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  x      <= grant_a;
                  y      <= grant_b;
                  rsp_id <= grant_id;
               end
            end
            CALC: begin
               // Larger operand is always the minuend, so no underflow.
               if (x == '0) begin
                  rsp_gcd <= y;
               end else if ((y == '0) || (x == y)) begin
                  rsp_gcd <= x;
               end else if (x > y) begin
                  x <= x - y;
               end else begin
                  y <= y - x;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  rr_ptr <= (int'(rsp_id) == N_REQ - 1) ? '0 : rsp_id + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp_valid = (state == DONE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_gcd_rr_scheduler.sv
// tb/tb_gcd_rr_scheduler.sv - scoreboard bench for gcd_rr_scheduler
module tb_gcd_rr_scheduler;

   localparam int N_REQ = 4;
   localparam int WIDTH = 8;
   localparam int ID_W  = 2;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] g;
      logic [31:0]      lat;
   } job_t;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [N_REQ-1:0]       req_valid = '0;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ*WIDTH-1:0] req_a = '0;
   logic [N_REQ*WIDTH-1:0] req_b = '0;
   logic                   rsp_valid;
   logic                   rsp_ready = 1'b0;
   logic [ID_W-1:0]        rsp_id;
   logic [WIDTH-1:0]       rsp_gcd;
   logic                   busy;

   gcd_rr_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_gcd   (rsp_gcd),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   job_t stim_q [N_REQ][$];
   job_t exp_q  [N_REQ][$];
   int   grant_log [$];

   int   cyc = 0;
   int   rdy_mode = 0;
   bit   gap_en = 1'b0;
   bit   inflight = 1'b0;
   bit   acc_pend = 1'b0;
   bit   fire_pend = 1'b0;
   bit   found;
   int   acc_id = 0;
   int   acc_cyc = 0;
   int   cur_lat = 0;
   int   m_id = 0;
   int   m_ptr = 0;
   int   kk;
   bit   exp_valid;
   logic [WIDTH-1:0] last_g = '0;
   int   last_id = 0;
   logic [N_REQ-1:0] exp_ready;
   job_t j;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void ref_gcd(input logic [WIDTH-1:0] a_in, input logic [WIDTH-1:0] b_in,
                                   output logic [WIDTH-1:0] g, output int steps);
      logic [WIDTH-1:0] a, b, t;
      a = a_in;
      b = b_in;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      g = a;
      a = a_in;
      b = b_in;
      steps = 0;
      while (a != 0 && b != 0 && a != b) begin
         if (a > b) a = a - b;
         else       b = b - a;
         steps++;
      end
   endfunction

   function automatic bit tb_idle();
      int pend = 0;
      for (int k = 0; k < N_REQ; k++) pend += stim_q[k].size();
      return (pend == 0) && (req_valid == '0) && !inflight && !acc_pend && !fire_pend;
   endfunction

   task automatic add(input int k, input int a, input int b, input int g, input int lat);
      job_t nj;
      nj.a   = WIDTH'(a);
      nj.b   = WIDTH'(b);
      nj.g   = WIDTH'(g);
      nj.lat = 32'(lat);
      stim_q[k].push_back(nj);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (!tb_idle() && n < budget) begin
         @(negedge clk);
         #3;
         n++;
      end
      check_eq("drain_timeout", 32'(n >= budget), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
      check_eq({tag, "_rsp_id"}, rsp_id, 0);
      check_eq({tag, "_rsp_gcd"}, rsp_gcd, 0);
      check_eq({tag, "_req_ready"}, req_ready, 0);
      check_eq({tag, "_busy"}, busy, 0);
   endtask

   // Per-cycle model: bookkeeping for the last edge, output checks,
   // stimulus drive, then prediction of what the next edge will do.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         if (inflight) void'(exp_q[m_id].pop_front());
         inflight  = 1'b0;
         acc_pend  = 1'b0;
         fire_pend = 1'b0;
         m_ptr     = 0;
         last_g    = '0;
         last_id   = 0;
      end else begin
         if (acc_pend) begin
            req_valid[acc_id] = 1'b0;
            inflight = 1'b1;
            m_id     = acc_id;
            cur_lat  = int'(exp_q[acc_id][0].lat);
            acc_pend = 1'b0;
         end
         if (fire_pend) begin
            inflight  = 1'b0;
            fire_pend = 1'b0;
         end

         check_eq("busy", busy, inflight);
         if (inflight) begin
            exp_valid = (cyc - acc_cyc) > cur_lat;
            check_eq("rsp_valid", rsp_valid, exp_valid);
            if (exp_valid) begin
               check_eq("rsp_gcd", rsp_gcd, exp_q[m_id][0].g);
               check_eq("rsp_id", rsp_id, m_id);
            end
         end else begin
            check_eq("rsp_valid_idle", rsp_valid, 0);
            check_eq("hold_gcd", rsp_gcd, last_g);
            check_eq("hold_id", rsp_id, last_id);
         end

         for (int k = 0; k < N_REQ; k++) begin
            if (!req_valid[k] && stim_q[k].size() > 0 && (!gap_en || $urandom_range(1) == 0)) begin
               j = stim_q[k].pop_front();
               req_a[k*WIDTH +: WIDTH] = j.a;
               req_b[k*WIDTH +: WIDTH] = j.b;
               req_valid[k] = 1'b1;
               exp_q[k].push_back(j);
            end
         end
         case (rdy_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = ($urandom_range(3) != 0);
            default: rsp_ready = 1'b0;
         endcase

         #1;
         exp_ready = '0;
         found     = 1'b0;
         if (!inflight) begin
            for (int i = 0; i < N_REQ; i++) begin
               kk = (m_ptr + i) % N_REQ;
               if (!found && req_valid[kk]) begin
                  found         = 1'b1;
                  exp_ready[kk] = 1'b1;
                  acc_id        = kk;
               end
            end
         end
         check_eq("req_ready", req_ready, exp_ready);
         if (found) begin
            acc_pend = 1'b1;
            acc_cyc  = cyc;
            grant_log.push_back(acc_id);
         end
         if (inflight && ((cyc - acc_cyc) > cur_lat) && rsp_ready) begin
            j         = exp_q[m_id].pop_front();
            last_g    = j.g;
            last_id   = m_id;
            m_ptr     = (m_id + 1) % N_REQ;
            fire_pend = 1'b1;
         end
      end
   end

   initial begin
      int n;
      int total;
      int rs;
      logic [WIDTH-1:0] ra, rb, rg;
      rst = 1'b1;
      #1;
      check_all_zero("reset");
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      #3;

      add(0, 12, 8, 4, 3);
      drain(200);

      grant_log.delete();
      add(1, 0, 5, 5, 1);
      add(2, 7, 0, 7, 1);
      add(3, 0, 0, 0, 1);
      add(0, 9, 9, 9, 1);
      drain(200);
      check_eq("zero_grants", grant_log.size(), 4);
      for (int i = 0; i < grant_log.size(); i++)
         check_eq("zero_order", grant_log[i], (i + 1) % N_REQ);

      rdy_mode = 2;
      add(0, 100, 75, 25, 4);
      n = 0;
      while (!rsp_valid && n < 50) begin
         @(negedge clk);
         #3;
         n++;
      end
      check_eq("bp_wait", rsp_valid, 1);
      add(2, 6, 4, 2, 3);
      repeat (20) @(negedge clk);
      #3;
      check_eq("bp_req_waiting", req_valid[2], 1);
      rdy_mode = 0;
      drain(200);

      add(0, 255, 1, 1, 255);
      drain(400);

      add(0, 255, 1, 1, 255);
      n = 0;
      while (!inflight && n < 20) begin
         @(negedge clk);
         #3;
         n++;
      end
      check_eq("abort_started", inflight, 1);
      repeat (100) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_all_zero("abort");
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (300) @(negedge clk);
      #3;
      add(3, 48, 18, 6, 5);
      drain(200);

      grant_log.delete();
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < N_REQ; k++)
            add(k, k + 2, 2 * (k + 2), k + 2, 2);
      drain(200);
      check_eq("rr_grants", grant_log.size(), 8);
      for (int i = 0; i < grant_log.size(); i++)
         check_eq("rr_order", grant_log[i], i % N_REQ);

      gap_en   = 1'b1;
      rdy_mode = 1;
      for (int i = 0; i < 2000; i++) begin
         ra = WIDTH'($urandom_range(255));
         rb = WIDTH'($urandom_range(255));
         ref_gcd(ra, rb, rg, rs);
         add($urandom_range(N_REQ - 1), int'(ra), int'(rb), int'(rg), rs + 1);
      end
      drain(60000);

      total = 0;
      for (int k = 0; k < N_REQ; k++) total += exp_q[k].size();
      check_eq("sb_empty", total, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
